// File: rtl/systolic_feeder.sv
// Operand feeder/sequencer for the MAC systolic array: captures A and B, clears the
// array, then streams skewed rows of A and columns of B into the array edges.

module systolic_feeder_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int K_DIM      = 2,
    parameter int LANE       = 0,
    parameter int TW         = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic [TW-1:0]               i_t,
    input  logic [K_DIM*DATA_WIDTH-1:0] i_vec,
    output logic [DATA_WIDTH-1:0]       o_data
);
    // One extra bit so t < LANE wraps to a value no k index can ever match.
    logic [TW:0]           w_k;
    logic [DATA_WIDTH-1:0] w_sel;

    assign w_k = {1'b0, i_t} - (TW+1)'(LANE);

    always_comb begin
        w_sel = '0;
        if (i_en) begin
            for (int k = 0; k < K_DIM; k++) begin
                if (w_k == (TW+1)'(k)) w_sel = i_vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_data <= '0;
        else          o_data <= w_sel;
    end
endmodule

module systolic_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int A_ROWS      = 2,
    parameter int B_COLS      = 2,
    parameter int K_DIM       = 2,
    parameter int MAC_LATENCY = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic [A_ROWS*K_DIM*DATA_WIDTH-1:0]   i_a_mat,
    input  logic [K_DIM*B_COLS*DATA_WIDTH-1:0]   i_b_mat,
    output logic [A_ROWS*DATA_WIDTH-1:0]         o_a,
    output logic [B_COLS*DATA_WIDTH-1:0]         o_b,
    output logic                                 o_array_clear,
    output logic                                 o_busy,
    output logic                                 o_done
);
    localparam int T  = K_DIM + A_ROWS + B_COLS - 2;
    localparam int TW = $clog2(T + MAC_LATENCY + 1);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);
    localparam logic [TW-1:0] D_LAST = TW'(T + MAC_LATENCY - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]                               r_state, w_nstate;
    logic [TW-1:0]                            r_t, w_nt;
    logic [A_ROWS*K_DIM*DATA_WIDTH-1:0]       r_a_mat;
    logic [K_DIM*B_COLS*DATA_WIDTH-1:0]       r_b_mat;
    logic                                     r_clear, r_busy, r_done;
    logic                                     w_capture, w_feed;

    assign w_capture = (r_state == ST_IDLE) && i_start;

    always_comb begin
        w_nstate = r_state;
        w_nt     = r_t;
        case (r_state)
            ST_IDLE: begin
                w_nt = '0;
                if (i_start) w_nstate = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_nt     = '0;
                w_nstate = ST_FEED;
            end
            ST_FEED: begin
                w_nt = r_t + 1'b1;
                if (r_t == T_LAST) w_nstate = (MAC_LATENCY == 0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                // t keeps counting through drain; sized so it never wraps.
                w_nt = r_t + 1'b1;
                if (r_t == D_LAST) w_nstate = ST_DONE;
            end
            ST_DONE: begin
                w_nt     = '0;
                w_nstate = ST_IDLE;
            end
            default: begin
                w_nt     = '0;
                w_nstate = ST_IDLE;
            end
        endcase
    end

    assign w_feed = (w_nstate == ST_FEED);

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_a_mat <= '0;
            r_b_mat <= '0;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_t     <= w_nt;
            if (w_capture) begin
                r_a_mat <= i_a_mat;
                r_b_mat <= i_b_mat;
            end
            r_clear <= (w_nstate == ST_CLEAR);
            r_busy  <= (w_nstate == ST_CLEAR) || (w_nstate == ST_FEED) || (w_nstate == ST_DRAIN);
            r_done  <= (w_nstate == ST_DONE);
        end
    end

    assign o_array_clear = r_clear;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_arow
        systolic_feeder_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .K_DIM      (K_DIM),
            .LANE       (gi),
            .TW         (TW)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_feed),
            .i_t     (w_nt),
            .i_vec   (r_a_mat[gi*K_DIM*DATA_WIDTH +: K_DIM*DATA_WIDTH]),
            .o_data  (o_a[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // B is stored row-major; gather each column into a contiguous K vector.
    for (genvar gj = 0; gj < B_COLS; gj++) begin : g_bcol
        logic [K_DIM*DATA_WIDTH-1:0] w_bcol;
        for (genvar gk = 0; gk < K_DIM; gk++) begin : g_k
            assign w_bcol[gk*DATA_WIDTH +: DATA_WIDTH] =
                r_b_mat[(gk*B_COLS+gj)*DATA_WIDTH +: DATA_WIDTH];
        end
        systolic_feeder_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .K_DIM      (K_DIM),
            .LANE       (gj),
            .TW         (TW)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_feed),
            .i_t     (w_nt),
            .i_vec   (w_bcol),
            .o_data  (o_b[gj*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: 2x2/K=2 instance plus a 3x2/K=4 instance, each driving
// a small behavioural MAC array so the final C matrix can be checked.

module tb_systolic_feeder;
    logic clk;
    logic rst_n;
    logic start, start2;
    logic [31:0] a_mat, b_mat;
    logic [15:0] o_a, o_b;
    logic clr, busy, done;
    logic [95:0] a_mat2;
    logic [63:0] b_mat2;
    logic [23:0] o_a2;
    logic [15:0] o_b2;
    logic clr2, busy2, done2;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    systolic_feeder u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_a_mat(a_mat), .i_b_mat(b_mat),
        .o_a(o_a), .o_b(o_b),
        .o_array_clear(clr), .o_busy(busy), .o_done(done)
    );

    systolic_feeder #(.DATA_WIDTH(8), .A_ROWS(3), .B_COLS(2), .K_DIM(4), .MAC_LATENCY(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
        .i_a_mat(a_mat2), .i_b_mat(b_mat2),
        .o_a(o_a2), .o_b(o_b2),
        .o_array_clear(clr2), .o_busy(busy2), .o_done(done2)
    );

    // Behavioural MAC array for instance 1 (2x2)
    logic [7:0] m1a [2][2];
    logic [7:0] m1b [2][2];
    logic [7:0] m1ain [2][2];
    logic [7:0] m1bin [2][2];
    int         m1c [2][2];

    always_comb begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                m1ain[i][j] = (j == 0) ? o_a[i*8 +: 8] : m1a[i][(j == 0) ? 0 : j-1];
                m1bin[i][j] = (i == 0) ? o_b[j*8 +: 8] : m1b[(i == 0) ? 0 : i-1][j];
            end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (clr) begin
                    m1a[i][j] <= '0; m1b[i][j] <= '0; m1c[i][j] <= 0;
                end else begin
                    m1a[i][j] <= m1ain[i][j];
                    m1b[i][j] <= m1bin[i][j];
                    m1c[i][j] <= m1c[i][j] + int'(m1ain[i][j]) * int'(m1bin[i][j]);
                end
            end
    end

    // Behavioural MAC array for instance 2 (3x2)
    logic [7:0] m2a [3][2];
    logic [7:0] m2b [3][2];
    logic [7:0] m2ain [3][2];
    logic [7:0] m2bin [3][2];
    int         m2c [3][2];

    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++) begin
                m2ain[i][j] = (j == 0) ? o_a2[i*8 +: 8] : m2a[i][(j == 0) ? 0 : j-1];
                m2bin[i][j] = (i == 0) ? o_b2[j*8 +: 8] : m2b[(i == 0) ? 0 : i-1][j];
            end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++) begin
                if (clr2) begin
                    m2a[i][j] <= '0; m2b[i][j] <= '0; m2c[i][j] <= 0;
                end else begin
                    m2a[i][j] <= m2ain[i][j];
                    m2b[i][j] <= m2bin[i][j];
                    m2c[i][j] <= m2c[i][j] + int'(m2ain[i][j]) * int'(m2bin[i][j]);
                end
            end
    end

    typedef struct {
        logic        clr;
        logic        busy;
        logic        done;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    vec_t tbl [2][9];
    int   cexp [2][4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a run from IDLE and compare cycles 1..8 against table ti.
    task automatic run_basic(input int ti, input logic [31:0] am, input logic [31:0] bm, input bit inject);
        a_mat = am;
        b_mat = bm;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (inject && c == 3) a_mat = 32'hDEADBEEF;
            if (inject && c == 4) start = 1'b1;
            if (inject && c == 5) start = 1'b0;
            chk($sformatf("t%0d c%0d clear", ti, c), {63'd0, clr},  {63'd0, tbl[ti][c].clr});
            chk($sformatf("t%0d c%0d busy",  ti, c), {63'd0, busy}, {63'd0, tbl[ti][c].busy});
            chk($sformatf("t%0d c%0d done",  ti, c), {63'd0, done}, {63'd0, tbl[ti][c].done});
            chk($sformatf("t%0d c%0d a",     ti, c), {48'd0, o_a},  {48'd0, tbl[ti][c].a});
            chk($sformatf("t%0d c%0d b",     ti, c), {48'd0, o_b},  {48'd0, tbl[ti][c].b});
            if (c == 7) begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        chk($sformatf("t%0d C[%0d][%0d]", ti, i, j), 64'(m1c[i][j]), 64'(cexp[ti][i*2+j]));
            end
            tick;
        end
    endtask

    int a2 [3][4];
    int b2 [4][2];
    int a2tab [7];
    int b2tab [7];
    int c2exp [6];

    initial begin
        // basic: A=[[1,2],[3,4]] B=[[5,6],[7,8]]
        tbl[0][0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[0][1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[0][2] = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0005};
        tbl[0][3] = '{1'b0, 1'b1, 1'b0, 16'h0302, 16'h0607};
        tbl[0][4] = '{1'b0, 1'b1, 1'b0, 16'h0400, 16'h0800};
        tbl[0][5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[0][6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[0][7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[0][8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        // max-value: all 255
        tbl[1][0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1][1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[1][2] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h00FF};
        tbl[1][3] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF};
        tbl[1][4] = '{1'b0, 1'b1, 1'b0, 16'hFF00, 16'hFF00};
        tbl[1][5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[1][6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[1][7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[1][8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        cexp[0] = '{19, 22, 43, 50};
        cexp[1] = '{130050, 130050, 130050, 130050};

        a2    = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{10, 11, 12, 13}};
        b2    = '{'{1, 20}, '{2, 21}, '{3, 22}, '{4, 23}};
        a2tab = '{0, 0, 10, 11, 12, 13, 0};
        b2tab = '{0, 20, 21, 22, 23, 0, 0};
        c2exp = '{30, 220, 70, 564, 120, 994};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        a_mat = '0; b_mat = '0; a_mat2 = '0; b_mat2 = '0;
        #12;
        chk("rst a",     {48'd0, o_a}, 64'd0);
        chk("rst b",     {48'd0, o_b}, 64'd0);
        chk("rst clear", {63'd0, clr}, 64'd0);
        chk("rst busy",  {63'd0, busy}, 64'd0);
        chk("rst done",  {63'd0, done}, 64'd0);
        chk("rst2 a",    {40'd0, o_a2}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick;

        run_basic(0, 32'h04030201, 32'h08070605, 1'b0);
        run_basic(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        // start during busy and a_mat change after capture
        run_basic(0, 32'h04030201, 32'h08070605, 1'b1);

        // asynchronous reset mid-FEED
        begin
            int ndone;
            ndone = 0;
            a_mat = 32'h04030201; b_mat = 32'h08070605; start = 1'b1;
            tick; start = 1'b0;
            tick; tick;
            #2 rst_n = 1'b0;
            #1;
            chk("async rst a",    {48'd0, o_a}, 64'd0);
            chk("async rst b",    {48'd0, o_b}, 64'd0);
            chk("async rst busy", {63'd0, busy}, 64'd0);
            chk("async rst clear", {63'd0, clr}, 64'd0);
            for (int c = 0; c < 8; c++) begin
                tick;
                if (done) ndone++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick;
                if (done) ndone++;
            end
            chk("no done after reset", 64'(ndone), 64'd0);
            run_basic(0, 32'h04030201, 32'h08070605, 1'b0);
        end

        // start held high: two runs with one IDLE gap
        a_mat = 32'h04030201; b_mat = 32'h08070605; start = 1'b1;
        tick;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("held c%0d clear", c), {63'd0, clr},  {63'd0, (c == 1 || c == 9)});
            chk($sformatf("held c%0d busy",  c), {63'd0, busy}, {63'd0, ((c >= 1 && c <= 6) || (c >= 9 && c <= 14))});
            chk($sformatf("held c%0d done",  c), {63'd0, done}, {63'd0, (c == 7 || c == 15)});
            if (c == 15) begin
                chk("held C00", 64'(m1c[0][0]), 64'd19);
                chk("held C11", 64'(m1c[1][1]), 64'd50);
                start = 1'b0;
            end
            tick;
        end

        // non-square 3x2, K=4, T=7
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) a_mat2[(i*4+k)*8 +: 8] = 8'(a2[i][k]);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 2; j++) b_mat2[(k*2+j)*8 +: 8] = 8'(b2[k][j]);
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c >= 2 && c <= 8) begin
                chk($sformatf("ns c%0d a2", c), {56'd0, o_a2[23:16]}, 64'(a2tab[c-2]));
                chk($sformatf("ns c%0d b1", c), {56'd0, o_b2[15:8]},  64'(b2tab[c-2]));
            end
            chk($sformatf("ns c%0d clear", c), {63'd0, clr2},  {63'd0, (c == 1)});
            chk($sformatf("ns c%0d busy",  c), {63'd0, busy2}, {63'd0, (c >= 1 && c <= 9)});
            chk($sformatf("ns c%0d done",  c), {63'd0, done2}, {63'd0, (c == 10)});
            if (c == 10) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 2; j++)
                        chk($sformatf("ns C[%0d][%0d]", i, j), 64'(m2c[i][j]), 64'(c2exp[i*2+j]));
            end
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
